spi_master_param: RTL and testbench

Parametrised SPI master. Transfers one DATA_W-bit word per start request, full duplex: MOSI out and MISO in. Clock rate, SPI mode (CPOL/CPHA) and SS setup/hold are set at elaboration. Used as the FPGA-side master for sensor/DAC links off the 50 MHz board clock, with a start/busy/done handshake to the control logic.

---
 rtl/spi_master_param.sv | 214 +++++++++++++++++++++
 tb/tb_spi_master_param.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// spi_master_param: parameterised full-duplex SPI master, one DATA_W-bit word
// per start request. SCL rate, CPOL/CPHA and SS lead/lag are elaboration-time
// parameters.
// Build option: define SPI_LSB_FIRST_EN to shift words LSB first on both MOSI
// and MISO; otherwise words are shifted MSB first. Timing is identical.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 100,
  parameter int CPOL    = 0,
  parameter int CPHA    = 1,
  parameter int SS_LEAD = 1,
  parameter int SS_LAG  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              SCL,
  output logic              SS,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int LL_MAX  = (SS_LEAD > SS_LAG) ? SS_LEAD : SS_LAG;
  localparam int CNT_MAX = (2 * DATA_W > LL_MAX) ? 2 * DATA_W : LL_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic SCL_IDLE       = (CPOL != 0);
  localparam logic SAMPLE_LEADING = (CPHA == 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_LAG
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                scl_q, scl_d;
  logic                ss_q, ss_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tick;
  logic                accept;
  logic [CNT_W-1:0]    edge_num;
  logic                last_edge;
  logic                lead_last;
  logic                lag_last;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                 input logic b);
    return {b, w[DATA_W-1:1]};
  endfunction
`else
  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                 input logic b);
    return {w[DATA_W-2:0], b};
  endfunction
`endif

  // Half-period tick and per-phase terminal conditions.
  always_comb begin
    tick      = (state_q != ST_IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
    accept    = (state_q == ST_IDLE) && start && !done_q;
    edge_num  = cnt_q + CNT_W'(1);
    last_edge = (edge_num == CNT_W'(2 * DATA_W));
    lead_last = (cnt_q == CNT_W'(SS_LEAD - 1));
    lag_last  = (cnt_q == CNT_W'(SS_LAG - 1));
  end

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      scl_q     <= SCL_IDLE;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      scl_q     <= scl_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state: IDLE -> LEAD -> XFER -> LAG -> IDLE, phases advance on ticks.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_LEAD;
      ST_LEAD: if (tick && lead_last) state_d = ST_XFER;
      ST_XFER: if (tick && last_edge) state_d = ST_LAG;
      ST_LAG:  if (tick && lag_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath: divider, phase/edge counter, shifters, handshake.
  always_comb begin
    div_d     = (state_q == ST_IDLE || tick) ? '0 : div_q + DIV_W'(1);
    cnt_d     = cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    scl_d     = scl_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          if (CPHA == 0) begin
            mosi_d  = out_bit(tx_data);
            tx_sh_d = shift_out(tx_data);
          end
        end
      end

      ST_LEAD: begin
        if (tick) cnt_d = lead_last ? '0 : cnt_q + CNT_W'(1);
      end

      ST_XFER: begin
        if (tick) begin
          scl_d = last_edge ? SCL_IDLE : ~scl_q;
          cnt_d = last_edge ? '0 : edge_num;
          // Odd edges are leading: the sampling edge is the leading one when
          // CPHA=0, the trailing one when CPHA=1; the other edge drives MOSI
          // (the final trailing edge has no bit left to drive).
          if (edge_num[0] == SAMPLE_LEADING) begin
            rx_sh_d = shift_in(rx_sh_q, MISO);
          end else if (!last_edge) begin
            mosi_d  = out_bit(tx_sh_q);
            tx_sh_d = shift_out(tx_sh_q);
          end
        end
      end

      ST_LAG: begin
        if (tick) begin
          if (lag_last) begin
            cnt_d     = '0;
            ss_d      = 1'b1;
            mosi_d    = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = rx_sh_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign SCL     = scl_q;
  assign SS      = ss_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: three instances (default mode with loopback,
// CPOL=0/CPHA=0 with a slave model, 16-bit CPOL=1/CPHA=1 with a slave model),
// scoreboard queues of expected rx words popped on each done pulse.
`timescale 1ns/1ps
module tb_spi_master_param;

  localparam int DIV1 = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: defaults, MISO looped back from MOSI
  logic       start0, busy0, done0, scl0, ss0, mosi0;
  logic [7:0] tx0, rx0;
  // Instance 1: mode 0, slave model
  logic       start1, busy1, done1, scl1, ss1, mosi1, miso1;
  logic [7:0] tx1, rx1;
  // Instance 2: 16-bit, mode 3, longer SS lead/lag
  logic        start2, busy2, done2, scl2, ss2, mosi2, miso2;
  logic [15:0] tx2, rx2;

  spi_master_param u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .tx_data(tx0), .busy(busy0),
    .done(done0), .rx_data(rx0), .SCL(scl0), .SS(ss0), .MOSI(mosi0),
    .MISO(mosi0)
  );

  spi_master_param #(
    .DATA_W(8), .CLK_DIV(DIV1), .CPOL(0), .CPHA(0), .SS_LEAD(1), .SS_LAG(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .busy(busy1),
    .done(done1), .rx_data(rx1), .SCL(scl1), .SS(ss1), .MOSI(mosi1),
    .MISO(miso1)
  );

  spi_master_param #(
    .DATA_W(16), .CLK_DIV(2), .CPOL(1), .CPHA(1), .SS_LEAD(2), .SS_LAG(3)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .tx_data(tx2), .busy(busy2),
    .done(done2), .rx_data(rx2), .SCL(scl2), .SS(ss2), .MOSI(mosi2),
    .MISO(miso2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];
  logic [15:0] exp2_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Position of the i-th transmitted bit within an n-bit word.
  function automatic int bpos(input int n, input int i);
`ifdef SPI_LSB_FIRST_EN
    return i;
`else
    return n - 1 - i;
`endif
  endfunction

  // Instance 0 monitor: MOSI on falling SCL, rising-edge spacing and count.
  logic [7:0] mon0   = '0;
  logic       first0 = 1'b0;
  int         midx0  = 0;
  int         rise0  = 0;
  int         last0  = 0;

  initial forever begin
    @(negedge ss0);
    mon0  = '0;
    midx0 = 0;
    rise0 = 0;
  end

  initial forever begin
    @(negedge scl0);
    if (ss0 === 1'b0) begin
      if (midx0 == 0) first0 = mosi0;
      if (midx0 < 8) mon0[bpos(8, midx0)] = mosi0;
      midx0++;
    end
  end

  initial forever begin
    @(posedge scl0);
    if (ss0 === 1'b0) begin
      rise0++;
      if (rise0 > 1) check("dut0_scl_period", cyc - last0, 200);
      last0 = cyc;
    end
  end

  // Instance 1 slave (mode 0): first bit valid at SS fall, shifts on falling
  // SCL, captures MOSI on rising SCL.
  logic [7:0] s1_word = '0;
  logic [7:0] s1_rx   = '0;
  int         s1_idx  = 0;

  initial forever begin
    @(negedge ss1);
    s1_idx = 0;
    s1_rx  = '0;
    miso1  = s1_word[bpos(8, 0)];
  end

  initial forever begin
    @(posedge scl1);
    if (ss1 === 1'b0 && s1_idx < 8) s1_rx[bpos(8, s1_idx)] = mosi1;
  end

  initial forever begin
    @(negedge scl1);
    if (ss1 === 1'b0) begin
      s1_idx++;
      if (s1_idx < 8) miso1 = s1_word[bpos(8, s1_idx)];
    end
  end

  // Instance 2 slave (mode 3): drives on falling SCL, captures on rising SCL.
  logic [15:0] s2_word  = '0;
  logic [15:0] s2_rx    = '0;
  int          s2_idx   = 0;
  int          s2_edges = 0;

  initial forever begin
    @(negedge ss2);
    s2_idx   = 0;
    s2_rx    = '0;
    s2_edges = 0;
  end

  initial forever begin
    @(negedge scl2);
    if (ss2 === 1'b0) begin
      s2_edges++;
      if (s2_idx < 16) miso2 = s2_word[bpos(16, s2_idx)];
    end
  end

  initial forever begin
    @(posedge scl2);
    if (ss2 === 1'b0) begin
      s2_edges++;
      if (s2_idx < 16) s2_rx[bpos(16, s2_idx)] = mosi2;
      s2_idx++;
    end
  end

  // Scoreboards: pop one expected word per done pulse.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b1 && done0 === 1'b1) begin
      if (exp0_q.size() > 0) check("dut0_rx_data", rx0, exp0_q.pop_front());
      else check("dut0_spurious_done", done0, 0);
      check("dut0_busy_with_done", busy0, 0);
    end
    if (rst === 1'b1 && done1 === 1'b1) begin
      if (exp1_q.size() > 0) check("dut1_rx_data", rx1, exp1_q.pop_front());
      else check("dut1_spurious_done", done1, 0);
      check("dut1_busy_with_done", busy1, 0);
    end
    if (rst === 1'b1 && done2 === 1'b1) begin
      if (exp2_q.size() > 0) check("dut2_rx_data", rx2, exp2_q.pop_front());
      else check("dut2_spurious_done", done2, 0);
      check("dut2_busy_with_done", busy2, 0);
    end
  end

  // Counts posedges until done is seen; an expired bound is a failure.
  task automatic wait_done(input int which, input int limit, output int n);
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      d = (which == 0) ? done0 : (which == 1) ? done1 : done2;
    end
    if (!d) check($sformatf("dut%0d_done_timeout", which), d, 1);
  endtask

  task automatic xfer0(input logic [7:0] w);
    int n;
    repeat (3) @(negedge clk);
    tx0    = w;
    start0 = 1'b1;
    exp0_q.push_back(16'(w));
    @(posedge clk);
    #1;
    start0 = 1'b0;
    tx0    = ~w;
    check("dut0_ss_low_after_start", ss0, 0);
    check("dut0_busy_after_start", busy0, 1);
    wait_done(0, 4000, n);
    check("dut0_done_latency", n, 1800);
    check("dut0_ss_high_at_done", ss0, 1);
    check("dut0_scl_rising_edges", rise0, 8);
    check("dut0_mosi_word", mon0, w);
    check("dut0_first_mosi_bit", first0, w[bpos(8, 0)]);
  endtask

  task automatic xfer1(input logic [7:0] tx, input logic [7:0] sw);
    int n;
    s1_word = sw;
    repeat (3) @(negedge clk);
    tx1    = tx;
    start1 = 1'b1;
    exp1_q.push_back(16'(sw));
    @(posedge clk);
    #1;
    start1 = 1'b0;
    tx1    = ~tx;
    check("dut1_mosi_first_bit_at_ss_fall", mosi1, tx[bpos(8, 0)]);
    wait_done(1, 1000, n);
    check("dut1_done_latency", n, 18 * DIV1);
    check("dut1_slave_rx", s1_rx, tx);
  endtask

  task automatic xfer2(input logic [15:0] tx, input logic [15:0] sw);
    int n;
    s2_word = sw;
    repeat (3) @(negedge clk);
    check("dut2_scl_idle_high", scl2, 1);
    tx2    = tx;
    start2 = 1'b1;
    exp2_q.push_back(sw);
    @(posedge clk);
    #1;
    start2 = 1'b0;
    tx2    = ~tx;
    check("dut2_ss_low_after_start", ss2, 0);
    wait_done(2, 200, n);
    check("dut2_done_latency", n, 74);
    check("dut2_scl_idle_after", scl2, 1);
    check("dut2_scl_edges", s2_edges, 32);
    check("dut2_slave_rx", s2_rx, tx);
  endtask

  logic [7:0] bw [3] = '{8'h96, 8'h3D, 8'hE7};

  initial begin
    int n;
    int acc;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tx0 = '0; tx1 = '0; tx2 = '0;
    miso1 = 1'b0; miso2 = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl0", scl0, 0);
    check("rst_ss0", ss0, 1);
    check("rst_mosi0", mosi0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_rx0", rx0, 0);
    check("rst_scl2", scl2, 1);
    check("rst_ss2", ss2, 1);
    @(negedge clk);
    rst = 1'b1;

    xfer0(8'hAB);
    xfer0(8'h01);
    xfer0(8'($urandom_range(255)));

    xfer1(8'h3C, 8'h96);
    xfer1(8'hC5, 8'h3B);
    xfer1(8'($urandom_range(255)), 8'($urandom_range(255)));

    xfer2(16'hA5F0, 16'h3C5A);
    xfer2(16'($urandom_range(65535)), 16'($urandom_range(65535)));

    // Back-to-back with start held high, plus mid-transfer start/tx_data noise.
    repeat (3) @(negedge clk);
    tx0    = bw[0];
    start0 = 1'b1;
    exp0_q.push_back(16'(bw[0]));
    @(posedge clk);
    #1;
    check("b2b_first_accept", busy0, 1);
    acc = cyc;
    for (int k = 0; k < 3; k++) begin
      repeat (600) @(posedge clk);
      #1;
      tx0    = 8'h00;
      start0 = 1'b0;
      @(posedge clk);
      #1;
      start0 = 1'b1;
      wait_done(0, 2000, n);
      check("b2b_done_latency", cyc - acc, 1800);
      check("b2b_mosi_word", mon0, bw[k]);
      if (k < 2) begin
        tx0 = bw[k+1];
        exp0_q.push_back(16'(bw[k+1]));
      end else begin
        start0 = 1'b0;
      end
      @(posedge clk);
      #1;
      check("b2b_start_ignored_in_done_cycle", busy0, 0);
      @(posedge clk);
      #1;
      check("b2b_accept_after_done", busy0, (k < 2) ? 1 : 0);
      acc = cyc;
    end

    // Reset mid-transfer: outputs return to idle at once, no done follows.
    repeat (3) @(negedge clk);
    tx0    = 8'h5A;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (500) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_scl", scl0, 0);
    check("midrst_ss", ss0, 1);
    check("midrst_mosi", mosi0, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_done", done0, 0);
    check("midrst_rx", rx0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2500) @(posedge clk);
    #1;
    check("midrst_rx_held", rx0, 0);
    check("midrst_ss_idle", ss0, 1);
    xfer0(8'hC3);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp0_q.size() + exp1_q.size() + exp2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
